fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the 5-stage pipelined RV32 core. Owns the program counter, drives the address port of the combinational instruction ROM, and loads the IF/ID pipeline register. Applies stalls and branch/jump redirects, and detects the halt word (0xFFFF_FFFF). On halt it drains the pipeline with NOPs and then asserts `halted`.

## Interface
- `ADDR_W`, 5: ROM word-address width; ROM depth is 2^ADDR_W words.
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `DRAIN_CYCLES`, 4: number of NOP cycles issued after the halt word before `halted` asserts.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rom_addr` out ADDR_W: word address to the ROM, equal to `pc[ADDR_W+1:2]`.
- `rom_instr` in 32: ROM data, combinational from `rom_addr` within the same cycle.
- `stall` in 1: hazard unit holds the IF stage.
- `redirect_valid` in 1: EX stage resolved a taken branch, `jal` or `jalr`.
- `redirect_pc` in 32: byte target; bits [1:0] are ignored (forced to 0).
- `if_pc` out 32: PC of the instruction in IF/ID.
- `if_instr` out 32: instruction in IF/ID.
- `if_valid` out 1: IF/ID holds a real, unsquashed instruction.
- `halted` out 1: core has stopped; level output, sticky until reset.

## Operation
- State machine: RUN, DRAIN, HALTED. Reset enters RUN.
- Reset values:
  - `pc` = RESET_PC
  - `if_pc` = 0
  - `if_instr` = 32'h0000_0013 (NOP)
  - `if_valid` = 0
  - `halted` = 0
  - drain counter = 0
- RUN, per-edge update, in priority order:
  1. `redirect_valid`: `pc` <= {redirect_pc[31:2],2'b0}; IF/ID <= NOP with `if_valid`=0. A redirect overrides `stall`.
  2. `stall`: `pc` and IF/ID hold.
  3. Otherwise: IF/ID <= {`pc`, `rom_instr`, valid=1}; `pc` <= `pc`+4.
  4. If case 3 loads `rom_instr` == 32'hFFFF_FFFF: go to DRAIN, counter <= 0, and hold `pc` at the halt word's address + 4.
- DRAIN:
  - Each unstalled cycle loads IF/ID with NOP, `if_valid`=0, and increments the counter. A stalled cycle holds everything.
  - Counter reaching DRAIN_CYCLES-1 on an unstalled edge: go to HALTED and set `halted`=1.
  - `redirect_valid` in DRAIN means the halt word was fetched speculatively. Cancel the halt: go to RUN, `pc` <= target, flush IF/ID, clear the counter.
- HALTED:
  - `pc` and IF/ID frozen (IF/ID holds NOP, invalid).
  - `stall` and `redirect_valid` are ignored.
  - Only `rst_n` exits.
- Arithmetic: `pc` is 32-bit and wraps modulo 2^32. `rom_addr` is a truncation, so a PC past the ROM end aliases to low addresses; no error is flagged.
- A halt word loaded under redirect is never acted on (case 1 wins).

## Timing
- ROM read is combinational. Fetch latency is 1 cycle: the word at `pc` appears on `if_instr` after the next rising edge.
- Redirect penalty: exactly one invalid IF/ID cycle. The target instruction is valid on the second edge after `redirect_valid` is sampled.
- Halt latency: `halted` rises DRAIN_CYCLES edges after the edge that loaded the halt word, plus any stalled cycles.
- Reset is asynchronous assert and synchronous deassert externally. All outputs take their reset values immediately on `rst_n`=0, including mid-DRAIN and in HALTED.
- `stall` and `redirect_valid` are sampled only at the rising edge; glitches between edges are don't-care.

## Structure
- Shared package `cpu_pkg`:
  - `NOP_INSTR` = 32'h0000_0013
  - `HALT_INSTR` = 32'hFFFF_FFFF
  - `fetch_state_t` enum {RUN, DRAIN, HALTED}
  - `XLEN` = 32
- One natural sub-module: `if_id_reg`. It holds pc, instr and valid, with enable (`!stall`) and flush (load NOP, invalid) inputs and an asynchronous active-low reset. The PC, FSM and drain counter stay in `fetch_ctrl`.
- The ROM is instantiated by the top level, not inside this block.

## Test plan
- Reset release, ROM word 0 = 0x00500513, word 1 = 0x014000EF, no stall → edge 1: `if_pc`=0, `if_instr`=0x00500513, `if_valid`=1. Edge 2: `if_pc`=4, `if_instr`=0x014000EF.
- Redirect at `pc`=0x08 with `redirect_pc`=0x1B → next cycle `rom_addr`=6, `if_valid`=0. Following edge: `if_pc`=0x18, `if_valid`=1.
- `stall`=1 for 3 cycles → `pc`, `if_pc` and `if_instr` unchanged across all 3 edges. `stall` and `redirect_valid` both high in one cycle → redirect taken, IF/ID flushed.
- ROM word 5 = 0xFFFF_FFFF → halt word appears valid with `if_pc`=0x14. Then 4 edges of NOP with `if_valid`=0, then `halted`=1. Later redirect pulses are ignored.
- Speculative halt: redirect to 0x58 two cycles into DRAIN → state returns to RUN, `halted` stays 0, instruction at word 22 fetched valid.
- `rst_n` pulsed low mid-DRAIN and again in HALTED → all outputs at reset values immediately, fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the RV32 pipeline front end.
// Instruction encodings used by fetch, plus the fetch controller state encoding.
package cpu_pkg;

  localparam int          XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: pc, instr, valid. Flush (NOP, invalid) wins over load.
// One-cycle latency; en low holds the contents, which is how stalls back-pressure the IF stage.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;
  logic            valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      // pc is left as-is: it is meaningless while valid is low
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (en_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, addresses the combinational ROM, loads IF/ID.
// Handles stall/redirect and drains the pipeline with NOPs after the halt word before halting.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int          ADDR_W       = 5,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [XLEN-1:0]   rom_instr,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_instr,
  output logic              if_valid,
  output logic              halted
);

  localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_t     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ifid_en;
  logic             ifid_flush;
  logic [XLEN-1:0]  redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_en = 1'b1;
          pc_d    = pc_q + 32'd4;
          if (rom_instr == HALT_INSTR) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        // A redirect here means the halt word was on a wrong path
        if (redirect_valid) begin
          state_d    = RUN;
          pc_d       = redirect_tgt;
          cnt_d      = '0;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_flush = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = HALTED;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HALTED: begin
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (ifid_en),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .instr_i (rom_instr),
    .pc_o    (if_pc),
    .instr_o (if_instr),
    .valid_o (if_valid)
  );

  assign rom_addr = pc_q[ADDR_W+1:2];
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized stall/redirect/reset traffic,
// compared every cycle against a transaction-level fetch model.
module tb_fetch_ctrl;
  import cpu_pkg::*;

  localparam int DRAIN_N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [4:0]  rom_addr;
  logic [31:0] rom_instr;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;

  logic [31:0] rom [32];
  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.ADDR_W(5), .RESET_PC(32'h0), .DRAIN_CYCLES(DRAIN_N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .halted         (halted)
  );

  assign rom_instr = rom[rom_addr];

  always #5 clk = ~clk;

  // Reference model: fetch as a sequence of events, drain tracked as "NOP slots still owed"
  logic [31:0] m_pc, m_ifpc, m_ifinstr, w;
  logic        m_ifvalid, m_halted;
  int          m_drain_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      m_halted = 1'b0; m_drain_left = 0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0; m_drain_left = 0;
    end else if (stall) begin
      m_halted = 1'b0;
    end else if (m_drain_left > 0) begin
      m_ifinstr = NOP_INSTR; m_ifvalid = 1'b0;
      m_drain_left = m_drain_left - 1;
      if (m_drain_left == 0) m_halted = 1'b1;
    end else begin
      w = rom[m_pc[6:2]];
      m_ifpc = m_pc; m_ifinstr = w; m_ifvalid = 1'b1;
      m_pc = m_pc + 32'd4;
      if (w == 32'hFFFF_FFFF) m_drain_left = DRAIN_N;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp_model();
    chk("m_rom_addr", 32'(rom_addr), 32'(m_pc[6:2]));
    chk("m_if_valid", 32'(if_valid), 32'(m_ifvalid));
    chk("m_if_instr", if_instr, m_ifinstr);
    if (m_ifvalid) chk("m_if_pc", if_pc, m_ifpc);
    chk("m_halted", 32'(halted), 32'(m_halted));
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    stall = st; redirect_valid = rd; redirect_pc = rpc;
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic do_reset();
    stall = 1'b0; redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, NOP_INSTR);
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] p, ins;
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0093 | (32'(i) << 20);
    rom[0] = 32'h0050_0513;
    rom[1] = 32'h0140_00EF;
    rom[5] = HALT_INSTR;
    #2;
    do_reset();

    step(0, 0, 0);
    chk("e1_if_pc", if_pc, 32'h0);
    chk("e1_if_instr", if_instr, 32'h0050_0513);
    chk("e1_if_valid", 32'(if_valid), 32'h1);
    step(0, 0, 0);
    chk("e2_if_pc", if_pc, 32'h4);
    chk("e2_if_instr", if_instr, 32'h0140_00EF);

    step(0, 1, 32'h1B);
    chk("redir_rom_addr", 32'(rom_addr), 32'h6);
    chk("redir_if_valid", 32'(if_valid), 32'h0);
    step(0, 0, 0);
    chk("redir_if_pc", if_pc, 32'h18);
    chk("redir_valid", 32'(if_valid), 32'h1);

    p = if_pc; ins = if_instr;
    repeat (3) begin
      step(1, 0, 0);
      chk("stall_if_pc", if_pc, p);
      chk("stall_if_instr", if_instr, ins);
      chk("stall_rom_addr", 32'(rom_addr), 32'h7);
    end
    step(1, 1, 32'hFFFF_FFFE);
    chk("stallredir_valid", 32'(if_valid), 32'h0);
    chk("stallredir_rom_addr", 32'(rom_addr), 32'd31);
    step(0, 0, 0);
    chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_rom_addr", 32'(rom_addr), 32'h0);

    step(0, 1, 32'h10);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("halt_if_pc", if_pc, 32'h14);
    chk("halt_if_instr", if_instr, HALT_INSTR);
    chk("halt_if_valid", 32'(if_valid), 32'h1);
    repeat (DRAIN_N - 1) begin
      step(0, 0, 0);
      chk("drain_halted", 32'(halted), 32'h0);
      chk("drain_if_valid", 32'(if_valid), 32'h0);
    end
    step(0, 0, 0);
    chk("halted_set", 32'(halted), 32'h1);
    repeat (3) step(0, 1, $urandom);
    chk("halted_sticky", 32'(halted), 32'h1);
    chk("halted_rom_addr", 32'(rom_addr), 32'h6);

    // Speculative halt cancelled by a redirect two cycles into drain
    do_reset();
    repeat (6) step(0, 0, 0);
    repeat (2) step(0, 0, 0);
    step(0, 1, 32'h58);
    chk("spec_halted", 32'(halted), 32'h0);
    step(0, 0, 0);
    chk("spec_if_pc", if_pc, 32'h58);
    chk("spec_if_instr", if_instr, rom[22]);
    chk("spec_if_valid", 32'(if_valid), 32'h1);

    // Reset mid-drain, then reset while halted
    do_reset();
    repeat (7) step(0, 0, 0);
    do_reset();
    step(0, 0, 0);
    chk("restart1_if_pc", if_pc, 32'h0);
    repeat (9) step(0, 0, 0);
    chk("halted_again", 32'(halted), 32'h1);
    do_reset();
    step(0, 0, 0);
    chk("restart2_if_pc", if_pc, 32'h0);

    // Randomized traffic
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++)
        rom[i] = ($urandom_range(0, 11) == 0) ? HALT_INSTR : $urandom;
      do_reset();
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
             ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 140)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
